// File: rtl/orca_color_console_pkg.sv
// Shared types and ANSI byte sequences for the colour console sink.
package orca_color_console_pkg;

    typedef logic [7:0]      ubyte_t;
    typedef logic [4:0][7:0] ansi_seq_t;

    typedef enum logic [1:0] {CC_IDLE, CC_PRE, CC_BODY, CC_POST} cc_state_t;

    localparam ubyte_t ASCII_ESC = 8'h1B;
    localparam ubyte_t ASCII_LF  = 8'h0A;

    // Index 0 is emitted first.
    localparam ansi_seq_t ANSI_RST = {ASCII_LF, 8'h6D, 8'h30, 8'h5B, ASCII_ESC};

    function automatic ansi_seq_t ansi_fg(input logic [3:0] d);
        return {8'h6D, 8'h30 + {4'h0, d}, 8'h39, 8'h5B, ASCII_ESC};
    endfunction

endpackage

// File: rtl/orca_color_console_if.sv
// Per-channel byte inputs and the shared coloured output stream.
interface orca_color_console_if #(parameter int NCH = 4);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0]   in_valid;
    logic [NCH*8-1:0] in_data;
    logic [NCH-1:0]   in_ready;
    logic             out_valid;
    logic [7:0]       out_data;
    logic [CHW-1:0]   out_ch;
    logic             out_ready;
    logic             busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch, busy
    );
endinterface

// File: rtl/orca_color_console_byte_fifo.sv
// Byte FIFO with occupancy count; push and pop may happen in the same cycle.
module orca_byte_fifo
    import orca_color_console_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  ubyte_t                   wdata,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output ubyte_t                   head
);
    localparam int AW = $clog2(DEPTH);

    ubyte_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/orca_color_console.sv
// Multi-channel console sink: emits whole lines wrapped in per-channel ANSI colour codes.
//   state   | meaning
//   IDLE    | waiting for a complete line or a full FIFO (forced flush)
//   PRE     | emitting ESC[9<d>m
//   BODY    | streaming line bytes from the granted channel FIFO
//   POST    | emitting ESC[0m LF
module orca_color_console
    import orca_color_console_pkg::*;
#(
    parameter int          NCH       = 4,
    parameter int          DEPTH     = 16,
    parameter logic [63:0] COLOR_MAP = 64'h3264
) (
    input logic                 clk,
    input logic                 rst_n,
    orca_color_console_if.slave bus
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW  = $clog2(DEPTH) + 1;

    cc_state_t      state, state_nxt;
    logic [CHW-1:0] ch_q, ch_nxt, rr_q, rr_nxt, grant;
    logic [CHW:0]   sum, grant_inc;
    logic           grant_ok, forced_q, forced_nxt, body_pop;
    logic [CW-1:0]  blen_q, blen_nxt;
    logic [2:0]     idx_q, idx_nxt;
    logic [3:0]     digit;
    ansi_seq_t      fg_seq;
    ubyte_t         head_sel, out_data;
    logic           out_valid;

    logic [NCH-1:0] push, pop, full, empty, pending;
    ubyte_t         head     [NCH];
    logic [CW-1:0]  count    [NCH];
    logic [CW-1:0]  line_cnt [NCH];

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic lf_in, lf_out;

        orca_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[i]),
            .wdata (bus.in_data[8*i +: 8]),
            .pop   (pop[i]),
            .full  (full[i]),
            .empty (empty[i]),
            .count (count[i]),
            .head  (head[i])
        );

        assign push[i]    = bus.in_valid[i] & ~full[i];
        assign lf_in      = push[i] && (bus.in_data[8*i +: 8] == ASCII_LF);
        assign lf_out     = pop[i] && (head[i] == ASCII_LF);
        assign pending[i] = (line_cnt[i] != '0) || full[i];

        always_ff @(posedge clk) begin
            if (!rst_n)                line_cnt[i] <= '0;
            else if (lf_in && !lf_out) line_cnt[i] <= line_cnt[i] + 1'b1;
            else if (!lf_in && lf_out) line_cnt[i] <= line_cnt[i] - 1'b1;
        end
    end

    assign bus.in_ready = ~full;
    assign pop          = body_pop ? ((NCH'(1) << ch_q) & ~empty) : '0;

    // Round-robin search from rr; descending loop so the nearest candidate wins.
    always_comb begin
        grant_ok = 1'b0;
        grant    = '0;
        sum      = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            sum = {1'b0, rr_q} + (CHW+1)'(k);
            if (sum >= (CHW+1)'(NCH)) sum = sum - (CHW+1)'(NCH);
            if (pending[sum[CHW-1:0]]) begin
                grant_ok = 1'b1;
                grant    = sum[CHW-1:0];
            end
        end
    end

    assign grant_inc = {1'b0, grant} + 1'b1;

    always_comb begin
        digit = '0;
        for (int i = 0; i < NCH; i++) begin
            if (ch_q == CHW'(i)) digit = COLOR_MAP[4*i +: 4];
        end
    end

    assign fg_seq   = ansi_fg(digit);
    assign head_sel = head[ch_q];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= CC_IDLE;
            ch_q     <= '0;
            rr_q     <= '0;
            forced_q <= 1'b0;
            blen_q   <= '0;
            idx_q    <= '0;
        end else begin
            state    <= state_nxt;
            ch_q     <= ch_nxt;
            rr_q     <= rr_nxt;
            forced_q <= forced_nxt;
            blen_q   <= blen_nxt;
            idx_q    <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ch_nxt     = ch_q;
        rr_nxt     = rr_q;
        forced_nxt = forced_q;
        blen_nxt   = blen_q;
        idx_nxt    = idx_q;
        out_valid  = 1'b0;
        out_data   = '0;
        body_pop   = 1'b0;
        case (state)
            CC_IDLE: begin
                if (grant_ok) begin
                    ch_nxt     = grant;
                    forced_nxt = (line_cnt[grant] == '0);
                    blen_nxt   = count[grant];
                    idx_nxt    = '0;
                    rr_nxt     = (grant_inc == (CHW+1)'(NCH)) ? '0 : grant_inc[CHW-1:0];
                    state_nxt  = CC_PRE;
                end
            end
            CC_PRE: begin
                out_valid = 1'b1;
                out_data  = fg_seq[idx_q];
                if (bus.out_ready) begin
                    idx_nxt = (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
                    if (idx_q == 3'd4) state_nxt = CC_BODY;
                end
            end
            CC_BODY: begin
                // A normal line's LF terminates it silently; POST supplies the LF.
                if (!forced_q && head_sel == ASCII_LF) begin
                    body_pop  = 1'b1;
                    state_nxt = CC_POST;
                end else begin
                    out_valid = 1'b1;
                    out_data  = head_sel;
                    if (bus.out_ready) begin
                        body_pop = 1'b1;
                        if (forced_q) begin
                            blen_nxt = blen_q - 1'b1;
                            if (blen_q == CW'(1)) state_nxt = CC_POST;
                        end
                    end
                end
            end
            CC_POST: begin
                out_valid = 1'b1;
                out_data  = ANSI_RST[idx_q];
                if (bus.out_ready) begin
                    idx_nxt = (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
                    if (idx_q == 3'd4) state_nxt = CC_IDLE;
                end
            end
            default: state_nxt = CC_IDLE;
        endcase
    end

    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_ch    = ch_q;
    assign bus.busy      = (state != CC_IDLE);

endmodule
